// File: rtl/signadd_pkg.sv
// signadd_pkg: shared FSM encoding and sizing helpers for the sign-magnitude adder sequencer.
package signadd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        ADD  = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_t;

    // Bit counter must reach bitNumber, so it needs clog2(bitNumber+1) bits.
    function automatic int cnt_w(input int bn);
        return $clog2(bn + 1);
    endfunction

    // Largest representable sign-magnitude magnitude, 2^(bn-1)-1.
    function automatic int max_mag(input int bn);
        return (1 << (bn - 1)) - 1;
    endfunction

endpackage

// File: rtl/signadd_seq_ctrl_if.sv
// signadd_seq_ctrl_if: operand/result handshake bundle.
// master (producer/consumer): drives in_valid, a_sm, b_sm, sub, out_ready.
// slave (sequencer): drives in_ready, out_valid, sum_sm, ovf, busy.
interface signadd_seq_ctrl_if #(parameter int bitNumber = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [bitNumber-1:0] a_sm;
    logic [bitNumber-1:0] b_sm;
    logic                 sub;
    logic                 out_valid;
    logic                 out_ready;
    logic [bitNumber-1:0] sum_sm;
    logic                 ovf;
    logic                 busy;

    modport master (
        output in_valid, a_sm, b_sm, sub, out_ready,
        input  in_ready, out_valid, sum_sm, ovf, busy
    );

    modport slave (
        input  in_valid, a_sm, b_sm, sub, out_ready,
        output in_ready, out_valid, sum_sm, ovf, busy
    );
endinterface

// File: rtl/sm2tc_conv.sv
// sm2tc_conv: combinational sign-magnitude to sign-extended (bitNumber+1)-bit two's complement.
// Ports: sm (bitNumber, MSB = sign) in; tc (bitNumber+1) out. -0 maps to 0.
module sm2tc_conv #(
    parameter int bitNumber = 8
) (
    input  logic [bitNumber-1:0] sm,
    output logic [bitNumber:0]   tc
);
    logic [bitNumber:0] mag;

    assign mag = {2'b00, sm[bitNumber-2:0]};
    assign tc  = sm[bitNumber-1] ? -mag : mag;
endmodule

// File: rtl/signadd_seq_ctrl.sv
// signadd_seq_ctrl: bit-serial sign-magnitude add/subtract sequencer, one operation in flight.
// Ports: clk1 (rising edge), rst_n (async, active-low), bus (signadd_seq_ctrl_if.slave):
//   operands a_sm/b_sm/sub accepted on in_valid&&in_ready; result sum_sm/ovf offered on
//   out_valid until out_ready; busy while not IDLE.
// Optional macro SIGNADD_SAT_EN: overflowed results saturate instead of truncating.
module signadd_seq_ctrl
    import signadd_pkg::*;
#(
    parameter int bitNumber = 8
) (
    input logic               clk1,
    input logic               rst_n,
    signadd_seq_ctrl_if.slave bus
);
    localparam int CW = cnt_w(bitNumber);
    localparam logic signed [bitNumber:0] MAX = (bitNumber + 1)'(max_mag(bitNumber));

    state_t               state_q, state_d;
    logic [bitNumber-1:0] a_sm_q, a_sm_d, b_sm_q, b_sm_d, sum_sm_q, sum_sm_d;
    logic [bitNumber:0]   a_tc_q, a_tc_d, b_tc_q, b_tc_d, acc_q, acc_d, a_tc_w, b_tc_w;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 carry_q, carry_d, ovf_q, ovf_d;
    logic signed [bitNumber:0] s;
    logic [bitNumber-2:0] mag_lo;
    logic                 abit, bbit;

    sm2tc_conv #(.bitNumber(bitNumber)) u_conv_a (.sm(a_sm_q), .tc(a_tc_w));
    sm2tc_conv #(.bitNumber(bitNumber)) u_conv_b (.sm(b_sm_q), .tc(b_tc_w));

    always_comb begin
        state_d  = state_q;
        a_sm_d   = a_sm_q;
        b_sm_d   = b_sm_q;
        a_tc_d   = a_tc_q;
        b_tc_d   = b_tc_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sum_sm_d = sum_sm_q;
        ovf_d    = ovf_q;
        s        = acc_q;
        mag_lo   = s[bitNumber] ? (bitNumber - 1)'(-s) : s[bitNumber-2:0];
        abit     = a_tc_q[cnt_q];
        bbit     = b_tc_q[cnt_q];
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_sm_d  = bus.a_sm;
                // Subtraction is folded in by flipping B's sign at capture.
                b_sm_d  = {bus.b_sm[bitNumber-1] ^ bus.sub, bus.b_sm[bitNumber-2:0]};
                state_d = CONV;
            end
            CONV: begin
                a_tc_d  = a_tc_w;
                b_tc_d  = b_tc_w;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                acc_d[cnt_q] = abit ^ bbit ^ carry_q;
                carry_d      = (abit & bbit) | (carry_q & (abit ^ bbit));
                cnt_d        = cnt_q + 1'b1;
                state_d      = (cnt_q == CW'(bitNumber)) ? PACK : ADD;
            end
            PACK: begin
                ovf_d    = (s > MAX) || (s < -MAX);
`ifdef SIGNADD_SAT_EN
                sum_sm_d = !ovf_d ? {s[bitNumber], mag_lo} :
                           s[bitNumber] ? '1 : {1'b0, {(bitNumber - 1){1'b1}}};
`else
                sum_sm_d = {s[bitNumber], mag_lo};
`endif
                state_d  = DONE;
            end
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sm_q   <= '0;
            b_sm_q   <= '0;
            a_tc_q   <= '0;
            b_tc_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_sm_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sm_q   <= a_sm_d;
            b_sm_q   <= b_sm_d;
            a_tc_q   <= a_tc_d;
            b_tc_q   <= b_tc_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sum_sm_q <= sum_sm_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum_sm    = sum_sm_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_signadd_seq_ctrl.sv
// tb_signadd_seq_ctrl: scoreboard bench for signadd_seq_ctrl (bitNumber = 8).
module tb_signadd_seq_ctrl;
    typedef struct {
        logic [7:0] sum;
        logic       ovf;
        int         acc;
    } exp_t;

`ifdef SIGNADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic ov_prev = 1'b0;
    exp_t q[$];

    signadd_seq_ctrl_if #(.bitNumber(8)) bus();
    signadd_seq_ctrl #(.bitNumber(8)) dut (.clk1(clk1), .rst_n(rst_n), .bus(bus));

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Integer reference: sign-magnitude decode, add, re-encode.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sb);
        int av, bv, sv, m;
        logic [7:0] r;
        logic o;
        av = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
        bv = (b[7] ^ sb) ? -int'(b[6:0]) : int'(b[6:0]);
        sv = av + bv;
        o  = (sv > 127) || (sv < -127);
        m  = (sv < 0) ? -sv : sv;
        r  = {sv < 0, m[6:0]};
        if (SAT && o) r = (sv < 0) ? 8'hFF : 8'h7F;
        return {o, r};
    endfunction

    // Monitor: latency check on each out_valid rise, value check on each handshake.
    always @(negedge clk1) begin
        if (!rst_n) ov_prev = 1'b0;
        else begin
            if (bus.out_valid && !ov_prev) begin
                chk("pending_on_valid", q.size(), 1);
                if (q.size() > 0) chk("latency", cyc - q[0].acc, 11);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("pending_on_hs", q.size(), 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum_sm", bus.sum_sm, e.sum);
                    chk("ovf", bus.ovf, e.ovf);
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk1); #1;
            t++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] es, input logic eo);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.a_sm     = a;
        bus.b_sm     = b;
        bus.sub      = s;
        @(posedge clk1); #1;
        q.push_back('{es, eo, cyc});
        bus.in_valid = 1'b0;
        bus.a_sm     = 8'($urandom);
        bus.b_sm     = 8'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk1); #1;
            t++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        logic [7:0] a, b;
        logic       s;
        logic [8:0] r;
        int         t;
        bus.in_valid  = 1'b0;
        bus.a_sm      = '0;
        bus.b_sm      = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum_sm", bus.sum_sm, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk1); #1;
        rst_n = 1'b1;
        issue(8'h05, 8'h83, 1'b0, 8'h02, 1'b0);
        issue(8'h85, 8'h03, 1'b0, 8'h82, 1'b0);
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b0);
        issue(8'h05, 8'h05, 1'b1, 8'h00, 1'b0);
        issue(8'h64, 8'h64, 1'b0, SAT ? 8'h7F : 8'h48, 1'b1);
        issue(8'hE4, 8'hE4, 1'b0, SAT ? 8'hFF : 8'hC8, 1'b1);
        issue(8'h3F, 8'h40, 1'b0, 8'h7F, 1'b0);
        issue(8'h40, 8'h40, 1'b0, SAT ? 8'h7F : 8'h00, 1'b1);
        issue(8'hC0, 8'hC0, 1'b0, SAT ? 8'hFF : 8'h80, 1'b1);
        issue(8'h7F, 8'hFF, 1'b0, 8'h00, 1'b0);
        issue(8'h7F, 8'h7F, 1'b1, 8'h00, 1'b0);
        drain();

        // Backpressure in DONE: result held, second request refused.
        bus.out_ready = 1'b0;
        issue(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(posedge clk1); #1;
            t++;
        end
        chk("bp_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum_stable", bus.sum_sm, 8'h33);
            chk("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = 1'b1;
            bus.a_sm     = 8'h07;
            bus.b_sm     = 8'h07;
            @(posedge clk1); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_still_valid", bus.out_valid, 1);
        chk("bp_sum_held", bus.sum_sm, 8'h33);
        bus.out_ready = 1'b1;
        @(posedge clk1); #1;
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        drain();

        // Reset in the 4th ADD cycle aborts the operation.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.a_sm     = 8'h10;
        bus.b_sm     = 8'h20;
        bus.sub      = 1'b0;
        @(posedge clk1); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk1); #1;
        end
        chk("mid_op_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_sum_sm", bus.sum_sm, 0);
        @(posedge clk1); #1;
        rst_n = 1'b1;
        issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        drain();

        // Back-to-back random operations against the integer model.
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            r = model(a, b, s);
            issue(a, b, s, r[7:0], r[8]);
        end
        drain();
        repeat (3) @(posedge clk1);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
